// File: rtl/wb_stream_mailbox.sv
// wb_stream_mailbox
//   Wishbone classic slave that bridges the bus to a pair of byte streams.
//   Bus writes to DATA are pushed into a TX FIFO, which drains to tx_*.
//   Words arriving on rx_* fill an RX FIFO, which bus reads of DATA pop.
//   The STATUS, CTRL and RX_LEVEL registers give software its flow control.
//
// Register map (offset from BASE):
//   0 DATA     W: push TX (rty when full)     R: pop RX (rty when empty)
//   1 STATUS   R: {rx_ovf, rx_full, rx_empty, tx_full, tx_empty}
//   2 CTRL     W: bit0 flush TX, bit1 flush RX, bit2 clear rx_ovf
//   3 RX_LEVEL R: RX occupancy
//
// Ports:
//   clk_i, rst_i                     clock, async active-low reset
//   adr_i, dat_i, we_i, stb_i,
//   sel_i, cyc_i                     Wishbone request
//   dat_o, ack_o, err_o, rty_o       registered Wishbone response
//   tx_valid_o, tx_data_o,
//   tx_ready_i                       outbound stream (show-ahead head)
//   rx_valid_i, rx_data_i,
//   rx_ready_o                       inbound stream
module wb_stream_mailbox #(
   parameter int unsigned       DWIDTH = 8,
   parameter int unsigned       AWIDTH = 16,
   parameter logic [AWIDTH-1:0] BASE   = '0,
   parameter int unsigned       DEPTH  = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [AWIDTH-1:0]   adr_i,
   input  logic [DWIDTH-1:0]   dat_i,
   input  logic                we_i,
   input  logic                stb_i,
   input  logic [DWIDTH/8-1:0] sel_i,
   input  logic                cyc_i,
   output logic [DWIDTH-1:0]   dat_o,
   output logic                ack_o,
   output logic                err_o,
   output logic                rty_o,
   output logic                tx_valid_o,
   output logic [DWIDTH-1:0]   tx_data_o,
   input  logic                tx_ready_i,
   input  logic                rx_valid_i,
   input  logic [DWIDTH-1:0]   rx_data_i,
   output logic                rx_ready_o
);

   localparam int unsigned   PW       = $clog2(DEPTH);
   localparam int unsigned   CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [AWIDTH-1:0] OFF_DATA   = AWIDTH'(0);
   localparam logic [AWIDTH-1:0] OFF_STATUS = AWIDTH'(1);
   localparam logic [AWIDTH-1:0] OFF_CTRL   = AWIDTH'(2);
   localparam logic [AWIDTH-1:0] OFF_LEVEL  = AWIDTH'(3);

   // Response registers
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              rty_q, rty_d;
   logic [DWIDTH-1:0] dat_q, dat_d;

   // FIFO storage and bookkeeping
   logic [DWIDTH-1:0] tx_mem [DEPTH];
   logic [DWIDTH-1:0] rx_mem [DEPTH];
   logic [PW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic              rx_ovf_q, rx_ovf_d;

   logic              tx_full, tx_empty, rx_full, rx_empty;
   logic              req;
   logic [AWIDTH-1:0] off;
   logic              tx_push, tx_pop, rx_push, rx_pop;
   logic              tx_flush, rx_flush, ovf_clr;

   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);

   // A response in flight blocks sampling, so a held strobe yields one response.
   assign req = cyc_i & stb_i & ~(ack_q | err_q | rty_q);
   assign off = adr_i - BASE;

   assign tx_pop  = ~tx_empty & tx_ready_i;
   assign rx_push = rx_valid_i & ~rx_full;

   always_comb begin
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rty_d    = 1'b0;
      dat_d    = '0;
      tx_push  = 1'b0;
      rx_pop   = 1'b0;
      tx_flush = 1'b0;
      rx_flush = 1'b0;
      ovf_clr  = 1'b0;
      if (req) begin
         case (off)
            OFF_DATA: begin
               if (we_i) begin
                  // Full is judged on registered state: a stream pop this
                  // same cycle does not make room for the bus write.
                  if (!sel_i[0]) begin
                     ack_d = 1'b1;
                  end else if (tx_full) begin
                     rty_d = 1'b1;
                  end else begin
                     tx_push = 1'b1;
                     ack_d   = 1'b1;
                  end
               end else if (rx_empty) begin
                  rty_d = 1'b1;
               end else begin
                  dat_d  = rx_mem[rx_rd_q];
                  rx_pop = 1'b1;
                  ack_d  = 1'b1;
               end
            end
            OFF_STATUS: begin
               if (we_i) begin
                  err_d = 1'b1;
               end else begin
                  dat_d = DWIDTH'({rx_ovf_q, rx_full, rx_empty, tx_full, tx_empty});
                  ack_d = 1'b1;
               end
            end
            OFF_CTRL: begin
               if (we_i) begin
                  tx_flush = dat_i[0];
                  rx_flush = dat_i[1];
                  ovf_clr  = dat_i[2];
               end
               ack_d = 1'b1;
            end
            OFF_LEVEL: begin
               if (we_i) begin
                  err_d = 1'b1;
               end else begin
                  dat_d = DWIDTH'(rx_cnt_q);
                  ack_d = 1'b1;
               end
            end
            default: err_d = 1'b1;
         endcase
      end

      // Flush discards everything, including a word handshaked this cycle.
      if (tx_flush) begin
         tx_wr_d  = '0;
         tx_rd_d  = '0;
         tx_cnt_d = '0;
      end else begin
         tx_wr_d  = tx_wr_q + PW'(tx_push);
         tx_rd_d  = tx_rd_q + PW'(tx_pop);
         tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      end

      if (rx_flush) begin
         rx_wr_d  = '0;
         rx_rd_d  = '0;
         rx_cnt_d = '0;
      end else begin
         rx_wr_d  = rx_wr_q + PW'(rx_push);
         rx_rd_d  = rx_rd_q + PW'(rx_pop);
         rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      end

      // An explicit clear takes priority over a same-cycle overflow.
      rx_ovf_d = (rx_ovf_q | (rx_valid_i & rx_full)) & ~ovf_clr;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rty_q    <= 1'b0;
         dat_q    <= '0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
         rx_ovf_q <= 1'b0;
      end else begin
         ack_q    <= ack_d;
         err_q    <= err_d;
         rty_q    <= rty_d;
         dat_q    <= dat_d;
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         rx_ovf_q <= rx_ovf_d;
      end
   end

   // Storage needs no reset: clearing the pointers is what empties a FIFO.
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wr_q] <= dat_i;
      if (rx_push) rx_mem[rx_wr_q] <= rx_data_i;
   end

   assign dat_o      = dat_q;
   assign ack_o      = ack_q;
   assign err_o      = err_q;
   assign rty_o      = rty_q;
   assign tx_valid_o = ~tx_empty;
   // Gated so the head reads 0 whenever the FIFO is empty, including in reset.
   assign tx_data_o  = tx_empty ? '0 : tx_mem[tx_rd_q];
   assign rx_ready_o = ~rx_full;

endmodule
